ddr3_dfi_responder: RTL and testbench

Synthesizable DFI-side responder that emulates a DDR3 device plus PHY behind the controller's DFI sequencer. It decodes DFI commands, tracks per-bank open rows, captures write bursts into an internal word RAM and returns read bursts on `dfi_rddata` after a fixed PHY latency. It is used in simulation and on-FPGA loopback builds to close the controller datapath without a real PHY, and it flags protocol violations through sticky error bits.

---
 rtl/ddr3_dfi_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_ddr3_dfi_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dfi_responder.sv
// DFI-side DDR3 device + PHY emulator: decodes commands, tracks open rows per bank,
// stores write bursts in a word RAM and returns read bursts after a fixed latency.

module ddr3_dfi_addr_queue #(
   parameter int W     = 14,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_empty,
   output logic         o_overflow
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_full;
   logic             w_pop;
   logic             w_push;

   assign o_empty    = (r_cnt == '0);
   assign w_full     = (r_cnt == CNT_W'(DEPTH));
   assign w_pop      = i_pop & ~o_empty;
   // a full queue still accepts a push when the head leaves in the same cycle
   assign w_push     = i_push & (~w_full | w_pop);
   assign o_overflow = i_push & w_full & ~w_pop;
   assign o_head     = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end
endmodule

module ddr3_dfi_responder #(
   parameter int DDR_COL_W   = 9,
   parameter int DDR_BANK_W  = 3,
   parameter int DDR_ROW_W   = 15,
   parameter int MEM_ROW_W   = 4,
   parameter int RDDATA_LAT  = 2,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DDR_ROW_W-1:0]  dfi_address_i,
   input  logic [DDR_BANK_W-1:0] dfi_bank_i,
   input  logic                  dfi_cs_n_i,
   input  logic                  dfi_ras_n_i,
   input  logic                  dfi_cas_n_i,
   input  logic                  dfi_we_n_i,
   input  logic                  dfi_cke_i,
   input  logic                  dfi_odt_i,
   input  logic                  dfi_reset_n_i,
   input  logic [31:0]           dfi_wrdata_i,
   input  logic                  dfi_wrdata_en_i,
   input  logic [3:0]            dfi_wrdata_mask_i,
   input  logic                  dfi_rddata_en_i,
   output logic [31:0]           dfi_rddata_o,
   output logic                  dfi_rddata_valid_o,
   output logic [1:0]            dfi_rddata_dnv_o,
   output logic [3:0]            error_o
);
   localparam int BANKS  = 1 << DDR_BANK_W;
   localparam int BASE_W = DDR_BANK_W + MEM_ROW_W + DDR_COL_W - 2;
   localparam int WORD_W = BASE_W + 2;

   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_RD  = 4'b0101;

   logic [BANKS-1:0]     r_bank_open;
   logic [MEM_ROW_W-1:0] r_bank_row [BANKS];
   logic [31:0]          r_ram [2**WORD_W];
   logic [1:0]           r_wr_beat;
   logic [1:0]           r_rd_beat;
   logic [3:0]           r_error;
   logic [RDDATA_LAT-1:0] r_pipe_vld;
   logic [31:0]          r_pipe_data [RDDATA_LAT];

   logic [3:0]           w_cmd;
   logic                 w_cmd_vld;
   logic                 w_is_act;
   logic                 w_is_pre;
   logic                 w_is_ref;
   logic                 w_is_wr;
   logic                 w_is_rd;
   logic                 w_sel_open;
   logic [BASE_W-1:0]    w_cmd_base;
   logic [BASE_W-1:0]    w_wq_head;
   logic [BASE_W-1:0]    w_rq_head;
   logic                 w_wq_empty;
   logic                 w_rq_empty;
   logic                 w_wq_ovf;
   logic                 w_rq_ovf;
   logic                 w_wr_pop;
   logic                 w_rd_pop;
   logic                 w_wr_do;
   logic [WORD_W-1:0]    w_wr_word;
   logic [WORD_W-1:0]    w_rd_word;
   logic [31:0]          w_rd_data;
   logic [3:0]           w_err_set;
   logic                 w_unused;

   assign w_cmd      = {dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i};
   assign w_cmd_vld  = dfi_cke_i & ~dfi_cs_n_i;
   assign w_is_act   = w_cmd_vld & (w_cmd == CMD_ACT);
   assign w_is_pre   = w_cmd_vld & (w_cmd == CMD_PRE);
   assign w_is_ref   = w_cmd_vld & (w_cmd == CMD_REF);
   assign w_is_wr    = w_cmd_vld & (w_cmd == CMD_WR);
   assign w_is_rd    = w_cmd_vld & (w_cmd == CMD_RD);
   assign w_sel_open = r_bank_open[dfi_bank_i];
   // column[1:0] is the beat within the burst and is supplied by the data strobes instead
   assign w_cmd_base = {dfi_bank_i, r_bank_row[dfi_bank_i], dfi_address_i[DDR_COL_W-1:2]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bank_open <= '0;
         for (int i = 0; i < BANKS; i++) r_bank_row[i] <= '0;
      end else if (w_is_act) begin
         r_bank_open[dfi_bank_i] <= 1'b1;
         r_bank_row[dfi_bank_i]  <= dfi_address_i[MEM_ROW_W-1:0];
      end else if (w_is_pre) begin
         if (dfi_address_i[10]) begin
            r_bank_open <= '0;
         end else begin
            r_bank_open[dfi_bank_i] <= 1'b0;
         end
      end
   end

   assign w_wr_pop = dfi_wrdata_en_i & (r_wr_beat == 2'd3);
   assign w_rd_pop = dfi_rddata_en_i & (r_rd_beat == 2'd3);

   ddr3_dfi_addr_queue #(.W(BASE_W), .DEPTH(QUEUE_DEPTH)) u_wr_queue (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_push     (w_is_wr),
      .i_data     (w_cmd_base),
      .i_pop      (w_wr_pop),
      .o_head     (w_wq_head),
      .o_empty    (w_wq_empty),
      .o_overflow (w_wq_ovf)
   );

   ddr3_dfi_addr_queue #(.W(BASE_W), .DEPTH(QUEUE_DEPTH)) u_rd_queue (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_push     (w_is_rd),
      .i_data     (w_cmd_base),
      .i_pop      (w_rd_pop),
      .o_head     (w_rq_head),
      .o_empty    (w_rq_empty),
      .o_overflow (w_rq_ovf)
   );

   assign w_wr_word = {w_wq_head, r_wr_beat};
   assign w_rd_word = {w_rq_head, r_rd_beat};
   assign w_wr_do   = dfi_wrdata_en_i & ~w_wq_empty & ~rst_i;
   // asynchronous read against the pre-edge array gives old data on a same-word collision
   assign w_rd_data = w_rq_empty ? 32'd0 : r_ram[w_rd_word];

   always_ff @(posedge clk_i) begin
      if (w_wr_do) begin
         for (int b = 0; b < 4; b++) begin
            if (!dfi_wrdata_mask_i[b]) r_ram[w_wr_word][8*b +: 8] <= dfi_wrdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < RDDATA_LAT; i++) r_pipe_data[i] <= '0;
      end else begin
         r_pipe_vld[0]  <= dfi_rddata_en_i;
         r_pipe_data[0] <= dfi_rddata_en_i ? w_rd_data : 32'd0;
         for (int i = 1; i < RDDATA_LAT; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
         end
      end
   end

   assign w_err_set[0] = (w_is_act & w_sel_open) | ((w_is_rd | w_is_wr) & ~w_sel_open);
   assign w_err_set[1] = w_wq_ovf | w_rq_ovf;
   assign w_err_set[2] = (dfi_wrdata_en_i & w_wq_empty) | (dfi_rddata_en_i & w_rq_empty);
   assign w_err_set[3] = w_is_ref & (|r_bank_open);

   // beat counters advance on every strobe so a stray strobe shifts the next burst's beats
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_beat <= '0;
         r_rd_beat <= '0;
         r_error   <= '0;
      end else begin
         if (dfi_wrdata_en_i) r_wr_beat <= r_wr_beat + 2'd1;
         if (dfi_rddata_en_i) r_rd_beat <= r_rd_beat + 2'd1;
         r_error <= r_error | w_err_set;
      end
   end

   assign dfi_rddata_o       = r_pipe_data[RDDATA_LAT-1];
   assign dfi_rddata_valid_o = r_pipe_vld[RDDATA_LAT-1];
   assign dfi_rddata_dnv_o   = 2'b00;
   assign error_o            = r_error;

   assign w_unused = ^{dfi_odt_i, dfi_reset_n_i, dfi_address_i};
endmodule

// File: tb/tb_ddr3_dfi_responder.sv
// Bench for ddr3_dfi_responder: directed vector table for the burst/error corner cases,
// then randomized traffic against a queue/array based reference model.
module tb_ddr3_dfi_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int MRW   = 4;

   localparam logic [3:0] C_LMR = 4'b0000;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_ZQ  = 4'b0110;
   localparam logic [3:0] C_NOP = 4'b0111;

   localparam logic [31:0] DA = 32'hAAAAAAAA;
   localparam logic [31:0] DP = 32'hAA55AA55;
   localparam logic [31:0] DQ = 32'h55AA55AA;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] addr;
   logic [2:0]  bank;
   logic        cs_n, ras_n, cas_n, we_n, cke, odt, reset_n;
   logic [31:0] wdata;
   logic        wen;
   logic [3:0]  wmask;
   logic        ren;
   logic [31:0] rdata;
   logic        rvalid;
   logic [1:0]  dnv;
   logic [3:0]  err;

   always #5 clk = ~clk;

   ddr3_dfi_responder #(.RDDATA_LAT(LAT), .QUEUE_DEPTH(DEPTH), .MEM_ROW_W(MRW)) dut (
      .clk_i(clk), .rst_i(rst), .dfi_address_i(addr), .dfi_bank_i(bank),
      .dfi_cs_n_i(cs_n), .dfi_ras_n_i(ras_n), .dfi_cas_n_i(cas_n), .dfi_we_n_i(we_n),
      .dfi_cke_i(cke), .dfi_odt_i(odt), .dfi_reset_n_i(reset_n),
      .dfi_wrdata_i(wdata), .dfi_wrdata_en_i(wen), .dfi_wrdata_mask_i(wmask),
      .dfi_rddata_en_i(ren), .dfi_rddata_o(rdata), .dfi_rddata_valid_o(rvalid),
      .dfi_rddata_dnv_o(dnv), .error_o(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic vld; logic [31:0] d; logic [3:0] km; } exp_t;

   bit          m_open [8];
   int          m_row  [8];
   int          m_wq[$];
   int          m_rq[$];
   int          m_wbeat, m_rbeat;
   logic [3:0]  m_err;
   logic [31:0] m_mem [int];
   logic [3:0]  m_kn  [int];
   exp_t        m_pend[$];

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
      m_wq.delete(); m_rq.delete();
      m_wbeat = 0; m_rbeat = 0; m_err = 4'd0;
      m_pend.delete();
      repeat (LAT - 1) m_pend.push_back('{1'b0, 32'd0, 4'hF});
   endtask

   task automatic model_cycle(input logic r, input logic [3:0] c, input logic [2:0] b,
                              input logic [14:0] a, input logic ck, input logic we,
                              input logic [31:0] wd, input logic [3:0] wm, input logic re,
                              output exp_t o);
      exp_t res;
      int idx, base;
      bit rpop, wpop, any;
      logic [31:0] tmp;
      logic [3:0]  kn;
      res = '{1'b0, 32'd0, 4'hF};
      rpop = 0; wpop = 0;
      if (r) begin
         model_reset();
      end else begin
         if (re) begin
            res.vld = 1'b1;
            if (m_rq.size() > 0) begin
               idx = m_rq[0] * 4 + m_rbeat;
               if (m_kn.exists(idx)) begin res.d = m_mem[idx]; res.km = m_kn[idx]; end
               else begin res.d = 32'd0; res.km = 4'h0; end
               rpop = (m_rbeat == 3);
            end else m_err[2] = 1'b1;
            m_rbeat = (m_rbeat + 1) % 4;
         end
         if (we) begin
            if (m_wq.size() > 0) begin
               idx = m_wq[0] * 4 + m_wbeat;
               tmp = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
               kn  = m_kn.exists(idx) ? m_kn[idx] : 4'h0;
               for (int k = 0; k < 4; k++)
                  if (!wm[k]) begin tmp[8*k +: 8] = wd[8*k +: 8]; kn[k] = 1'b1; end
               m_mem[idx] = tmp; m_kn[idx] = kn;
               wpop = (m_wbeat == 3);
            end else m_err[2] = 1'b1;
            m_wbeat = (m_wbeat + 1) % 4;
         end
         if (ck && !c[3]) begin
            case (c)
               C_ACT: begin
                  if (m_open[b]) m_err[0] = 1'b1;
                  m_open[b] = 1; m_row[b] = int'(a) % (1 << MRW);
               end
               C_PRE: begin
                  if (a[10]) for (int i = 0; i < 8; i++) m_open[i] = 0;
                  else m_open[b] = 0;
               end
               C_REF: begin
                  any = 0;
                  for (int i = 0; i < 8; i++) if (m_open[i]) any = 1;
                  if (any) m_err[3] = 1'b1;
               end
               C_RD, C_WR: begin
                  if (!m_open[b]) m_err[0] = 1'b1;
                  base = int'(b) * (1 << (MRW + 7)) + m_row[b] * 128 + (int'(a) % 512) / 4;
                  if (c == C_RD) begin
                     if (m_rq.size() - int'(rpop) < DEPTH) m_rq.push_back(base);
                     else m_err[1] = 1'b1;
                  end else begin
                     if (m_wq.size() - int'(wpop) < DEPTH) m_wq.push_back(base);
                     else m_err[1] = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if (rpop) void'(m_rq.pop_front());
         if (wpop) void'(m_wq.pop_front());
      end
      m_pend.push_back(res);
      o = m_pend.pop_front();
   endtask

   task automatic step(input logic r, input logic [3:0] c, input logic [2:0] b,
                       input logic [14:0] a, input logic ck, input logic we,
                       input logic [31:0] wd, input logic [3:0] wm, input logic re);
      exp_t e;
      logic [31:0] m;
      rst = r; {cs_n, ras_n, cas_n, we_n} = c; bank = b; addr = a; cke = ck;
      wen = we; wdata = wd; wmask = wm; ren = re;
      model_cycle(r, c, b, a, ck, we, wd, wm, re, e);
      @(posedge clk);
      #1;
      m = {{8{e.km[3]}}, {8{e.km[2]}}, {8{e.km[1]}}, {8{e.km[0]}}};
      chk("model_valid", 32'(rvalid), 32'(e.vld));
      if (!e.vld || e.km != 4'h0) chk("model_rddata", rdata & m, e.d & m);
      chk("model_error", 32'(err), 32'(m_err));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic rst; logic [3:0] cmd; logic [2:0] bank; logic [14:0] addr;
      logic wen; logic [31:0] wd; logic [3:0] wm; logic ren;
      logic ev; logic [31:0] ed; logic [3:0] ee;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t V(logic r, logic [3:0] c, logic [2:0] b, logic [14:0] a, logic we,
                              logic [31:0] wd, logic [3:0] wm, logic re,
                              logic ev, logic [31:0] ed, logic [3:0] ee);
      vec_t t;
      t.rst = r; t.cmd = c; t.bank = b; t.addr = a; t.wen = we; t.wd = wd; t.wm = wm;
      t.ren = re; t.ev = ev; t.ed = ed; t.ee = ee;
      return t;
   endfunction
   function automatic vec_t C(logic [3:0] c, logic [2:0] b, logic [14:0] a,
                              logic ev, logic [31:0] ed, logic [3:0] ee);
      return V(0, c, b, a, 0, 0, 0, 0, ev, ed, ee);
   endfunction
   function automatic vec_t W(logic [31:0] wd, logic [3:0] wm, logic [3:0] ee);
      return V(0, C_NOP, 0, 0, 1, wd, wm, 0, 0, 0, ee);
   endfunction
   function automatic vec_t R(logic ev, logic [31:0] ed, logic [3:0] ee);
      return V(0, C_NOP, 0, 0, 0, 0, 0, 1, ev, ed, ee);
   endfunction
   function automatic vec_t RS();
      return V(1, C_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   logic [31:0] pat [4];

   initial begin
      int sel;
      logic [3:0] rc;
      logic [14:0] ra;
      pat[0] = DA; pat[1] = DP; pat[2] = DQ; pat[3] = DA;
      rst = 1; addr = 0; bank = 0; {cs_n, ras_n, cas_n, we_n} = C_NOP; cke = 1;
      odt = 0; reset_n = 1; wdata = 0; wen = 0; wmask = 0; ren = 0;

      repeat (3) step(1, C_NOP, 0, 0, 1, 0, 0, 0, 0);
      chk("reset_valid", 32'(rvalid), 32'd0);
      chk("reset_rddata", rdata, 32'd0);
      chk("reset_error", 32'(err), 32'd0);
      chk("reset_dnv", 32'(dnv), 32'd0);

      // basic write burst then read burst
      tbl.push_back(C(C_ACT, 2, 15'd5, 0, 0, 0));
      tbl.push_back(C(C_WR, 2, 15'h010, 0, 0, 0));
      for (int k = 0; k < 4; k++) tbl.push_back(W(32'h11111111 * (k + 1), 4'h0, 0));
      tbl.push_back(C(C_RD, 2, 15'h010, 0, 0, 0));
      tbl.push_back(R(0, 0, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(R(1, 32'h11111111 * (k + 1), 0));
      tbl.push_back(C(C_NOP, 0, 0, 1, 32'h44444444, 0));
      tbl.push_back(C(C_NOP, 0, 0, 0, 0, 0));
      // byte-masked overwrite
      tbl.push_back(C(C_WR, 2, 15'h010, 0, 0, 0));
      for (int k = 0; k < 4; k++) tbl.push_back(W(DA, 4'h0, 0));
      tbl.push_back(C(C_WR, 2, 15'h010, 0, 0, 0));
      tbl.push_back(W(32'h0, 4'hF, 0));
      tbl.push_back(W(32'h55555555, 4'b1010, 0));
      tbl.push_back(W(32'h55555555, 4'b0101, 0));
      tbl.push_back(W(32'h0, 4'hF, 0));
      tbl.push_back(C(C_RD, 2, 15'h010, 0, 0, 0));
      tbl.push_back(R(0, 0, 0));
      tbl.push_back(R(1, DA, 0));
      tbl.push_back(R(1, DP, 0));
      tbl.push_back(R(1, DQ, 0));
      tbl.push_back(C(C_NOP, 0, 0, 1, DA, 0));
      tbl.push_back(C(C_NOP, 0, 0, 0, 0, 0));
      // bank state violations
      tbl.push_back(RS());
      tbl.push_back(C(C_RD, 3, 15'd0, 0, 0, 4'h1));
      tbl.push_back(RS());
      tbl.push_back(C(C_ACT, 1, 15'd1, 0, 0, 0));
      tbl.push_back(C(C_ACT, 1, 15'd1, 0, 0, 4'h1));
      tbl.push_back(RS());
      tbl.push_back(C(C_ACT, 1, 15'd1, 0, 0, 0));
      tbl.push_back(C(C_PRE, 0, 15'h400, 0, 0, 0));
      tbl.push_back(C(C_RD, 1, 15'd0, 0, 0, 4'h1));
      tbl.push_back(RS());
      // queue overflow, draining, empty strobe, refresh with open bank
      tbl.push_back(C(C_ACT, 2, 15'd5, 0, 0, 0));
      for (int k = 0; k < 4; k++) tbl.push_back(C(C_RD, 2, 15'h010, 0, 0, 0));
      tbl.push_back(C(C_RD, 2, 15'h010, 0, 0, 4'h2));
      tbl.push_back(R(0, 0, 4'h2));
      for (int k = 1; k < 16; k++) tbl.push_back(R(1, pat[(k - 1) % 4], 4'h2));
      tbl.push_back(R(1, DA, 4'h6));
      tbl.push_back(C(C_NOP, 0, 0, 1, 32'd0, 4'h6));
      tbl.push_back(C(C_ACT, 0, 15'd0, 0, 0, 4'h6));
      tbl.push_back(C(C_REF, 0, 15'd0, 0, 0, 4'hE));
      // reset in the middle of a read burst
      tbl.push_back(RS());
      tbl.push_back(C(C_ACT, 2, 15'd5, 0, 0, 0));
      tbl.push_back(C(C_ACT, 2, 15'd5, 0, 0, 4'h1));
      tbl.push_back(C(C_RD, 2, 15'h010, 0, 0, 4'h1));
      tbl.push_back(R(0, 0, 4'h1));
      tbl.push_back(R(1, DA, 4'h1));
      tbl.push_back(R(1, DP, 4'h1));
      tbl.push_back(V(1, C_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(R(0, 0, 4'h4));
      tbl.push_back(C(C_NOP, 0, 0, 1, 32'd0, 4'h4));
      tbl.push_back(RS());
      tbl.push_back(C(C_ACT, 2, 15'd5, 0, 0, 0));
      tbl.push_back(C(C_RD, 2, 15'h010, 0, 0, 0));
      tbl.push_back(R(0, 0, 0));
      tbl.push_back(R(1, DA, 0));
      tbl.push_back(R(1, DP, 0));
      tbl.push_back(R(1, DQ, 0));
      tbl.push_back(C(C_NOP, 0, 0, 1, DA, 0));
      tbl.push_back(C(C_NOP, 0, 0, 0, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].cmd, tbl[i].bank, tbl[i].addr, 1'b1,
              tbl[i].wen, tbl[i].wd, tbl[i].wm, tbl[i].ren);
         chk($sformatf("vec%0d_valid", i), 32'(rvalid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_rddata", i), rdata, tbl[i].ed);
         chk($sformatf("vec%0d_error", i), 32'(err), 32'(tbl[i].ee));
      end

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         sel = $urandom_range(0, 15);
         ra  = 15'($urandom) & 15'h7E1F;
         case (sel)
            0, 1, 2:    begin rc = C_ACT; ra = (15'($urandom) & 15'h7FF0) | 15'($urandom_range(0, 3)); end
            3, 4, 5:    rc = C_RD;
            6, 7, 8:    rc = C_WR;
            9:          begin rc = C_PRE; ra[10] = ($urandom_range(0, 3) == 0); end
            10:         rc = C_REF;
            11:         rc = C_LMR;
            12:         rc = C_ZQ;
            13, 14:     rc = C_NOP;
            default:    rc = {1'b1, 3'($urandom)};
         endcase
         step(($urandom_range(0, 149) == 0), rc, 3'($urandom_range(0, 2)), ra,
              ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 4), $urandom,
              ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), ($urandom_range(0, 9) < 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
